// File: rtl/mem_stage_lsu_if.sv
// rtl/mem_stage_lsu_if.sv - data-memory request/grant/response bus of the LSU
//
// Purpose: bundles the LSU-to-data-memory signals so the stage and the memory
//          model connect through one port.
// Signals (named from the LSU side):
//   mem_req_o    request, held until granted
//   mem_we_o     1 = write
//   mem_addr_o   address aligned down to XLEN/8 bytes
//   mem_be_o     byte enables, one per lane
//   mem_wdata_o  store data already shifted into its byte lanes
//   mem_gnt_i    request accepted
//   mem_rvalid_i read data valid
//   mem_rdata_i  full aligned read word
// Modports: master = LSU side, slave = memory side.

interface mem_stage_lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic                mem_req_o;
  logic                mem_we_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [XLEN/8-1:0]   mem_be_o;
  logic [XLEN-1:0]     mem_wdata_o;
  logic                mem_gnt_i;
  logic                mem_rvalid_i;
  logic [XLEN-1:0]     mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - memory-stage load/store unit between execute and writeback
//
// Purpose: accepts one operation at a time from execute, performs byte/half/word
//          (and double when XLEN=64) accesses on the data-memory bus, extracts and
//          extends load data, and flags misaligned or illegal-size accesses without
//          touching memory.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   valid_i / ready_o               execute handshake (ready_o high only in IDLE)
//   op_i, size_i, unsigned_i        operation, access size, zero-extend select
//   addr_i, wdata_i, rd_i           byte address, store/pass-through data, dest tag
//   mem (master)                    data-memory request/grant/response bus
//   valid_o / ready_i               writeback handshake
//   result_o, rd_o, misalign_o      load data or pass-through value, tag, exception

module mem_stage_lsu #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [1:0]          op_i,
  input  logic [1:0]          size_i,
  input  logic                unsigned_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [XLEN-1:0]     wdata_i,
  input  logic [4:0]          rd_i,
  mem_stage_lsu_if.master     mem,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [XLEN-1:0]     result_o,
  output logic [4:0]          rd_o,
  output logic                misalign_o
);

  localparam int NB = XLEN / 8;
  localparam int LW = $clog2(NB);

  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t          state;
  logic            is_load_q;
  logic [1:0]      size_q;
  logic            unsigned_q;
  logic [LW-1:0]   lane_q;

  // 2^sz low lanes set; sizes wider than the bus saturate to all lanes.
  function automatic logic [NB-1:0] be_base_f(input logic [1:0] sz);
    logic [NB-1:0] b;
    b = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < (1 << sz)) b[i] = 1'b1;
    end
    return b;
  endfunction

  function automatic logic [XLEN-1:0] byte_mask_f(input logic [NB-1:0] b);
    logic [XLEN-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) begin
      m[8*i +: 8] = {8{b[i]}};
    end
    return m;
  endfunction

  // Acceptance-side decode
  logic [LW-1:0]   lane_i;
  logic [2:0]      align_mask;
  logic            acc_illegal;
  logic [NB-1:0]   be_i;
  logic [XLEN-1:0] wdata_lane;

  assign lane_i = addr_i[LW-1:0];

  always_comb begin
    align_mask = 3'b000;
    case (size_i)
      2'd0: align_mask = 3'b000;
      2'd1: align_mask = 3'b001;
      2'd2: align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  end

  assign acc_illegal = ((size_i == 2'd3) && (XLEN == 32)) || (|(addr_i[2:0] & align_mask));
  assign be_i        = be_base_f(size_i) << lane_i;
  assign wdata_lane  = (wdata_i & byte_mask_f(be_base_f(size_i))) << {lane_i, 3'b000};

  // Load extraction from the latched lane/size
  logic [XLEN-1:0] rd_shifted;
  logic [XLEN-1:0] ld_mask;
  logic            sign_bit;
  logic [XLEN-1:0] ld_ext;

  assign rd_shifted = mem.mem_rdata_i >> {lane_q, 3'b000};
  assign ld_mask    = byte_mask_f(be_base_f(size_q));

  always_comb begin
    sign_bit = 1'b0;
    case (size_q)
      2'd0: sign_bit = rd_shifted[7];
      2'd1: sign_bit = rd_shifted[15];
      2'd2: sign_bit = rd_shifted[31];
      default: sign_bit = rd_shifted[XLEN-1];
    endcase
  end

  // A full-width access has an all-ones mask, so the fill term vanishes on its own.
  assign ld_ext = (rd_shifted & ld_mask) | (~ld_mask & {XLEN{sign_bit & ~unsigned_q}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      ready_o         <= 1'b1;
      valid_o         <= 1'b0;
      misalign_o      <= 1'b0;
      result_o        <= '0;
      rd_o            <= '0;
      mem.mem_req_o   <= 1'b0;
      mem.mem_we_o    <= 1'b0;
      mem.mem_addr_o  <= '0;
      mem.mem_be_o    <= '0;
      mem.mem_wdata_o <= '0;
      is_load_q       <= 1'b0;
      size_q          <= '0;
      unsigned_q      <= 1'b0;
      lane_q          <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (valid_i) begin
            ready_o    <= 1'b0;
            rd_o       <= rd_i;
            misalign_o <= 1'b0;
            is_load_q  <= (op_i == OP_LOAD);
            size_q     <= size_i;
            unsigned_q <= unsigned_i;
            lane_q     <= lane_i;
            if ((op_i == OP_LOAD) || (op_i == OP_STORE)) begin
              if (acc_illegal) begin
                misalign_o <= 1'b1;
                result_o   <= '0;
                valid_o    <= 1'b1;
                state      <= S_DONE;
              end else begin
                result_o        <= '0;
                mem.mem_req_o   <= 1'b1;
                mem.mem_we_o    <= (op_i == OP_STORE);
                mem.mem_addr_o  <= {addr_i[ADDR_W-1:LW], {LW{1'b0}}};
                mem.mem_be_o    <= be_i;
                mem.mem_wdata_o <= wdata_lane;
                state           <= S_REQ;
              end
            end else begin
              result_o <= wdata_i;
              valid_o  <= 1'b1;
              state    <= S_DONE;
            end
          end
        end
        S_REQ: begin
          if (mem.mem_gnt_i) begin
            mem.mem_req_o <= 1'b0;
            mem.mem_we_o  <= 1'b0;
            if (is_load_q) begin
              state <= S_WAIT;
            end else begin
              valid_o <= 1'b1;
              state   <= S_DONE;
            end
          end
        end
        S_WAIT: begin
          if (mem.mem_rvalid_i) begin
            result_o <= ld_ext;
            valid_o  <= 1'b1;
            state    <= S_DONE;
          end
        end
        default: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            state   <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - scoreboard bench for mem_stage_lsu at XLEN=32 and XLEN=64

module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        valid;
  logic [1:0]  op, size;
  logic        uns;
  logic [31:0] addr;
  logic [63:0] wdata, rdata;
  logic [4:0]  rd;
  logic        gnt, rvalid, ready_in;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [63:0] result;
    bit          chk_res;
    logic [4:0]  rd;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mem_stage_lsu_if #(.XLEN(32), .ADDR_W(32)) m32 ();
  mem_stage_lsu_if #(.XLEN(64), .ADDR_W(32)) m64 ();

  assign m32.mem_gnt_i    = gnt;
  assign m32.mem_rvalid_i = rvalid;
  assign m32.mem_rdata_i  = rdata[31:0];
  assign m64.mem_gnt_i    = gnt;
  assign m64.mem_rvalid_i = rvalid;
  assign m64.mem_rdata_i  = rdata;

  logic        rdy32, val32, mis32, rdy64, val64, mis64;
  logic [31:0] res32;
  logic [63:0] res64;
  logic [4:0]  rd32, rd64;

  mem_stage_lsu #(.XLEN(32), .ADDR_W(32)) u32 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid & ~sel), .ready_o(rdy32),
    .op_i(op), .size_i(size), .unsigned_i(uns), .addr_i(addr),
    .wdata_i(wdata[31:0]), .rd_i(rd), .mem(m32.master),
    .valid_o(val32), .ready_i(ready_in), .result_o(res32), .rd_o(rd32),
    .misalign_o(mis32)
  );

  mem_stage_lsu #(.XLEN(64), .ADDR_W(32)) u64 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid & sel), .ready_o(rdy64),
    .op_i(op), .size_i(size), .unsigned_i(uns), .addr_i(addr),
    .wdata_i(wdata), .rd_i(rd), .mem(m64.master),
    .valid_o(val64), .ready_i(ready_in), .result_o(res64), .rd_o(rd64),
    .misalign_o(mis64)
  );

  // Observed view of whichever instance is selected
  logic        o_ready, o_valid, o_mis, o_req, o_we;
  logic [63:0] o_result, o_wdata;
  logic [4:0]  o_rd;
  logic [31:0] o_addr;
  logic [7:0]  o_be;

  assign o_ready  = sel ? rdy64 : rdy32;
  assign o_valid  = sel ? val64 : val32;
  assign o_mis    = sel ? mis64 : mis32;
  assign o_result = sel ? res64 : {32'h0, res32};
  assign o_rd     = sel ? rd64 : rd32;
  assign o_req    = sel ? m64.mem_req_o : m32.mem_req_o;
  assign o_we     = sel ? m64.mem_we_o : m32.mem_we_o;
  assign o_addr   = sel ? m64.mem_addr_o : m32.mem_addr_o;
  assign o_be     = sel ? m64.mem_be_o : {4'h0, m32.mem_be_o};
  assign o_wdata  = sel ? m64.mem_wdata_o : {32'h0, m32.mem_wdata_o};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [1:0] a_op, input logic [1:0] a_size, input logic a_uns,
                        input logic [31:0] a_addr, input logic [63:0] a_wdata,
                        input logic [4:0] a_rd, input bit push, input logic [63:0] e_res,
                        input bit e_chk_res, input logic e_mis);
    exp_t e;
    chk("ready_o_before_accept", {63'h0, o_ready}, 64'h1);
    e.result = e_res; e.chk_res = e_chk_res; e.rd = a_rd; e.mis = e_mis;
    if (push) sb.push_back(e);
    op = a_op; size = a_size; uns = a_uns; addr = a_addr; wdata = a_wdata; rd = a_rd;
    valid = 1'b1;
    step();
    valid = 1'b0;
    wdata = '0;
  endtask

  // Request phase with gnt held low gnt_delay cycles; loads then see rvalid k cycles after grant.
  task automatic mem_phase(input bit is_load, input int gnt_delay, input int k,
                           input logic [63:0] rd_data, input logic [31:0] e_addr,
                           input logic [7:0] e_be, input logic [63:0] e_wdata);
    for (int i = 0; i <= gnt_delay; i++) begin
      chk("mem_req_o", {63'h0, o_req}, 64'h1);
      chk("mem_we_o", {63'h0, o_we}, {63'h0, ~is_load});
      chk("mem_addr_o", {32'h0, o_addr}, {32'h0, e_addr});
      chk("mem_be_o", {56'h0, o_be}, {56'h0, e_be});
      if (!is_load) chk("mem_wdata_o", o_wdata, e_wdata);
      chk("valid_o_in_req", {63'h0, o_valid}, 64'h0);
      if (i < gnt_delay) step();
    end
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    chk("mem_req_o_after_gnt", {63'h0, o_req}, 64'h0);
    if (is_load) begin
      for (int j = 1; j < k; j++) begin
        chk("valid_o_in_wait", {63'h0, o_valid}, 64'h0);
        step();
      end
      chk("valid_o_before_rvalid", {63'h0, o_valid}, 64'h0);
      rdata = rd_data;
      rvalid = 1'b1;
      step();
      rvalid = 1'b0;
      rdata = '0;
    end
  endtask

  // Compare the DONE state against the scoreboard, holding ready_i low for hold cycles.
  task automatic drain(input int hold);
    exp_t e;
    n_chk++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed size %0d expected >0", sb.size());
    end
    if (sb.size() > 0) e = sb.pop_front();
    else e = '{result: '0, chk_res: 1'b0, rd: '0, mis: 1'b0};
    for (int i = 0; i <= hold; i++) begin
      chk("valid_o", {63'h0, o_valid}, 64'h1);
      if (e.chk_res) chk("result_o", o_result, e.result);
      chk("rd_o", {59'h0, o_rd}, {59'h0, e.rd});
      chk("misalign_o", {63'h0, o_mis}, {63'h0, e.mis});
      chk("ready_o_busy", {63'h0, o_ready}, 64'h0);
      if (i < hold) step();
    end
    ready_in = 1'b1;
    step();
    ready_in = 1'b0;
    chk("valid_o_after_hs", {63'h0, o_valid}, 64'h0);
    chk("ready_o_after_hs", {63'h0, o_ready}, 64'h1);
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; valid = 1'b0; op = '0; size = '0; uns = 1'b0;
    addr = '0; wdata = '0; rdata = '0; rd = '0; gnt = 1'b0; rvalid = 1'b0; ready_in = 1'b0;
    step();
    step();
    chk("rst_ready_o", {63'h0, o_ready}, 64'h1);
    chk("rst_valid_o", {63'h0, o_valid}, 64'h0);
    chk("rst_misalign_o", {63'h0, o_mis}, 64'h0);
    chk("rst_mem_req_o", {63'h0, o_req}, 64'h0);
    chk("rst_mem_we_o", {63'h0, o_we}, 64'h0);
    chk("rst_mem_addr_o", {32'h0, o_addr}, 64'h0);
    chk("rst_mem_be_o", {56'h0, o_be}, 64'h0);
    chk("rst_mem_wdata_o", o_wdata, 64'h0);
    chk("rst_result_o", o_result, 64'h0);
    chk("rst_rd_o", {59'h0, o_rd}, 64'h0);
    rst_n = 1'b1;
    step();

    // XLEN=32: signed byte load from lane 3
    accept(2'd1, 2'd0, 1'b0, 32'h103, 64'h0, 5'd3, 1'b1, 64'h0000_0000_FFFF_FF80, 1'b1, 1'b0);
    mem_phase(1'b1, 0, 1, 64'h8000_0000, 32'h100, 8'h08, 64'h0);
    drain(0);

    // Same load zero-extended, rvalid two cycles after grant
    accept(2'd1, 2'd0, 1'b1, 32'h103, 64'h0, 5'd4, 1'b1, 64'h0000_0000_0000_0080, 1'b1, 1'b0);
    mem_phase(1'b1, 0, 2, 64'h8000_0000, 32'h100, 8'h08, 64'h0);
    drain(1);

    // Half store to lane 2 with grant held off 3 cycles
    accept(2'd2, 2'd1, 1'b0, 32'h202, 64'hDEAD_BEEF, 5'd7, 1'b1, 64'h0, 1'b0, 1'b0);
    mem_phase(1'b0, 3, 0, 64'h0, 32'h200, 8'h0C, 64'h0000_0000_BEEF_0000);
    drain(0);

    // Misaligned word load: no request, valid the next cycle
    accept(2'd1, 2'd2, 1'b0, 32'h101, 64'h0, 5'd9, 1'b1, 64'h0, 1'b1, 1'b1);
    chk("misaligned_no_req", {63'h0, o_req}, 64'h0);
    drain(0);

    // Double-size access is illegal at XLEN=32
    accept(2'd1, 2'd3, 1'b0, 32'h8, 64'h0, 5'd10, 1'b1, 64'h0, 1'b1, 1'b1);
    chk("size3_no_req", {63'h0, o_req}, 64'h0);
    drain(0);

    // Pass-through with writeback stalled 2 cycles
    accept(2'd0, 2'd0, 1'b0, 32'h55, 64'h1234, 5'd5, 1'b1, 64'h1234, 1'b1, 1'b0);
    drain(2);

    // Signed half load from upper half, grant delayed one cycle
    accept(2'd1, 2'd1, 1'b0, 32'h102, 64'h0, 5'd11, 1'b1, 64'h0000_0000_FFFF_ABCD, 1'b1, 1'b0);
    mem_phase(1'b1, 1, 1, 64'hABCD_0000, 32'h100, 8'h0C, 64'h0);
    drain(0);

    // Reset while waiting for grant abandons the store
    accept(2'd2, 2'd2, 1'b0, 32'h300, 64'h1111_2222, 5'd12, 1'b0, 64'h0, 1'b0, 1'b0);
    chk("pre_reset_req", {63'h0, o_req}, 64'h1);
    rst_n = 1'b0;
    #1;
    chk("reset_req_drop", {63'h0, o_req}, 64'h0);
    chk("reset_valid_drop", {63'h0, o_valid}, 64'h0);
    chk("reset_ready_high", {63'h0, o_ready}, 64'h1);
    step();
    rst_n = 1'b1;
    gnt = 1'b1;
    step();
    step();
    gnt = 1'b0;
    chk("post_reset_no_req", {63'h0, o_req}, 64'h0);
    chk("post_reset_no_valid", {63'h0, o_valid}, 64'h0);

    // XLEN=64 instance
    sel = 1'b1;
    accept(2'd1, 2'd3, 1'b0, 32'h8, 64'h0, 5'd1, 1'b1, 64'h8000_0000_0000_0001, 1'b1, 1'b0);
    mem_phase(1'b1, 0, 1, 64'h8000_0000_0000_0001, 32'h8, 8'hFF, 64'h0);
    drain(0);

    accept(2'd1, 2'd2, 1'b0, 32'h4, 64'h0, 5'd2, 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b1, 1'b0);
    mem_phase(1'b1, 0, 1, 64'h8000_0000_0000_0000, 32'h0, 8'hF0, 64'h0);
    drain(0);

    accept(2'd2, 2'd0, 1'b0, 32'h5, 64'hFFFF_FFFF_FFFF_FFAB, 5'd3, 1'b1, 64'h0, 1'b0, 1'b0);
    mem_phase(1'b0, 1, 0, 64'h0, 32'h0, 8'h20, 64'h0000_AB00_0000_0000);
    drain(0);

    accept(2'd1, 2'd3, 1'b0, 32'hC, 64'h0, 5'd4, 1'b1, 64'h0, 1'b1, 1'b1);
    chk("x64_misaligned_no_req", {63'h0, o_req}, 64'h0);
    drain(0);

    accept(2'd3, 2'd1, 1'b0, 32'h7, 64'h0123_4567_89AB_CDEF, 5'd31, 1'b1,
           64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
    drain(0);

    chk("scoreboard_drained", 64'(sb.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Parametrised load/store unit for the memory-access pipeline stage, sitting between execute and writeback. Accepts one operation at a time from execute through a valid/ready handshake and issues byte/half/word (and doubleword when XLEN=64) accesses to a data memory with a request/grant/response protocol. Load data is lane-extracted and sign- or zero-extended before it goes to writeback. Misaligned accesses are flagged as exceptions without touching memory.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64
- ADDR_W, 32, byte-address width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- valid_i  in  1  execute presents an operation
- ready_o  out  1  stage can accept; high only in IDLE
- op_i  in  2  0=NONE (pass-through), 1=LOAD, 2=STORE, 3=reserved (treated as NONE)
- size_i  in  2  0=byte, 1=half, 2=word, 3=double (legal only when XLEN=64)
- unsigned_i  in  1  zero-extend loads when 1
- addr_i  in  ADDR_W  byte address / ALU result
- wdata_i  in  XLEN  store data, or pass-through value for NONE
- rd_i  in  5  destination register tag
- mem_req_o  out  1  memory request, held until granted
- mem_we_o  out  1  1=write
- mem_addr_o  out  ADDR_W  address aligned down to XLEN/8 bytes
- mem_be_o  out  XLEN/8  byte enables
- mem_wdata_o  out  XLEN  store data shifted into byte lanes
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  XLEN  read data, full aligned word
- valid_o  out  1  result for writeback
- ready_i  in  1  writeback accepts
- result_o  out  XLEN  load data or pass-through value
- rd_o  out  5  destination tag
- misalign_o  out  1  exception: access not naturally aligned or size illegal

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: ready_o=1. On valid_i: latch all inputs. Then:
  - NONE/reserved: result=wdata_i, next DONE.
  - LOAD/STORE misaligned (addr low bits not multiple of 2^size_i) or size_i=3 with XLEN=32: misalign_o=1, result=0, no memory request, next DONE.
  - Otherwise next REQ.
- REQ: mem_req_o=1, addr/be/we/wdata stable. On mem_gnt_i: STORE → DONE, LOAD → WAIT.
- WAIT: on mem_rvalid_i, latch extracted/extended data, → DONE.
- DONE: valid_o=1, outputs stable; on ready_i → IDLE.
- Byte enables: 2^size_i consecutive ones starting at lane addr[log2(XLEN/8)-1:0].
- Store data: low 2^size_i bytes of wdata_i shifted left by lane*8; unused lanes 0.
- Load extract: rdata shifted right by lane*8, truncated to 2^size_i bytes, sign-extended from top bit unless unsigned_i or size equals XLEN.
- rd_o carried through unchanged for all ops; misalign_o cleared on next acceptance.

## Timing
- Reset (async assert, sync release): state IDLE; ready_o=1; mem_req_o, mem_we_o, valid_o, misalign_o=0; mem_addr_o, mem_be_o, mem_wdata_o, result_o, rd_o=0.
- NONE / misaligned: accept cycle N, valid_o at N+1.
- Store, gnt on first REQ cycle: mem_req_o at N+1, valid_o at N+2.
- Load, gnt at N+1, rvalid at N+1+k (k≥1): valid_o at N+2+k.
- mem_rvalid_i never arrives in the grant cycle; rvalid in any state other than WAIT is ignored.
- Stalls: mem_gnt_i low holds REQ with all mem_* stable; ready_i low holds DONE with outputs stable.
- Back-to-back: after DONE handshake at cycle M, next acceptance at M+1 earliest (one bubble).
- Reset mid-operation abandons the transaction; no request or valid after reset release.

## Test plan
- Reset during REQ with mem_gnt_i low → mem_req_o and valid_o drop to 0 immediately, ready_o=1.
- XLEN=32, LOAD byte addr 0x103, rdata 0x80_00_00_00, unsigned_i=0 → mem_addr_o=0x100, mem_be_o=4'b1000, result_o=0xFFFF_FF80; unsigned_i=1 → 0x0000_0080.
- STORE half addr 0x202, wdata 0xDEAD_BEEF, gnt delayed 3 cycles → mem_be_o=4'b1100, mem_wdata_o=0xBEEF_0000, mem_we_o=1, held stable 3 cycles, valid_o one cycle after gnt.
- LOAD word addr 0x101 → misalign_o=1, valid_o at N+1, mem_req_o never asserted.
- XLEN=64, LOAD double addr 0x8, rdata 0x8000_0000_0000_0001 → result unchanged; size 3 with XLEN=32 → misalign_o=1.
- NONE op, wdata 0x1234, rd 5, ready_i low 2 cycles → valid_o held, result_o=0x1234, rd_o=5, ready_o=0 until handshake.
